// File: rtl/friscv_uart_host_if.sv
// Register-port bus between the UART host (master) and the UART slave register file.
// Request fields are held by the master until the one-cycle mst_ready pulse.
interface friscv_uart_host_if #(
    parameter int ADDRW = 16,
    parameter int XLEN  = 32
);
    logic                mst_en;
    logic                mst_wr;
    logic [ADDRW-1:0]    mst_addr;
    logic [XLEN-1:0]     mst_wdata;
    logic [XLEN/8-1:0]   mst_strb;
    logic [XLEN-1:0]     mst_rdata;
    logic                mst_ready;

    modport master (
        output mst_en, mst_wr, mst_addr, mst_wdata, mst_strb,
        input  mst_rdata, mst_ready
    );

    modport slave (
        input  mst_en, mst_wr, mst_addr, mst_wdata, mst_strb,
        output mst_rdata, mst_ready
    );
endinterface

// File: rtl/friscv_uart_host.sv
// Register-port initiator for the UART: initialises divider/control, then polls status
// and moves bytes between the TX/RX streams and the UART FIFOs without stalling the bus.
module friscv_uart_host #(
    parameter int         ADDRW       = 16,
    parameter int         XLEN        = 32,
    parameter int         CLK_DIVIDER = 4,
    parameter logic [7:0] CTRL_INIT   = 8'h01,
    parameter int         POLL_GAP    = 8
) (
    input  logic                aclk,
    input  logic                srst,
    friscv_uart_host_if.master  mst,
    input  logic                tx_valid,
    output logic                tx_ready,
    input  logic [7:0]          tx_data,
    output logic                rx_valid,
    input  logic                rx_ready,
    output logic [7:0]          rx_data,
    output logic                cfg_done,
    output logic [15:0]         status
);

    localparam int CNT_W = (POLL_GAP < 1) ? 1 : $clog2(POLL_GAP + 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((POLL_GAP < 1) ? 0 : POLL_GAP - 1);

    localparam logic [2:0] INIT_DIV  = 3'd0;
    localparam logic [2:0] INIT_CTRL = 3'd1;
    localparam logic [2:0] GAP       = 3'd2;
    localparam logic [2:0] POLL      = 3'd3;
    localparam logic [2:0] TX_WR     = 3'd4;
    localparam logic [2:0] RX_RD     = 3'd5;

    logic [2:0]        state;
    logic [CNT_W-1:0]  gap_cnt;
    logic              bypass;
    logic              prio_rx;
    logic              tx_full;
    logic [7:0]        tx_hold;

    logic              tx_hs;
    logic              rx_hs;
    logic              acc_done;
    logic              tx_elig;
    logic              rx_elig;

    logic              req_wr;
    logic [ADDRW-1:0]  req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic [XLEN/8-1:0] req_strb;

    assign tx_hs    = tx_valid & tx_ready;
    assign rx_hs    = rx_valid & rx_ready;
    assign acc_done = mst.mst_en & mst.mst_ready;
    // Bit 10 flags TX FIFO full, bit 11 flags RX FIFO empty
    assign tx_elig  = tx_full & ~mst.mst_rdata[10];
    assign rx_elig  = ~rx_valid & ~mst.mst_rdata[11];

    always_comb begin
        req_wr    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_strb  = '0;
        case (state)
            INIT_DIV: begin
                req_wr    = 1'b1;
                req_addr  = ADDRW'(1);
                req_wdata = XLEN'(CLK_DIVIDER);
                req_strb  = (XLEN/8)'(4'b0011);
            end
            INIT_CTRL: begin
                req_wr    = 1'b1;
                req_addr  = ADDRW'(0);
                req_wdata = XLEN'(CTRL_INIT);
                req_strb  = (XLEN/8)'(4'b0001);
            end
            POLL: begin
                req_addr  = ADDRW'(0);
            end
            TX_WR: begin
                req_wr    = 1'b1;
                req_addr  = ADDRW'(2);
                req_wdata = XLEN'(tx_hold);
                req_strb  = (XLEN/8)'(4'b0001);
            end
            RX_RD: begin
                req_addr  = ADDRW'(3);
            end
            default: ;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (srst) begin
            state         <= INIT_DIV;
            gap_cnt       <= '0;
            bypass        <= 1'b0;
            prio_rx       <= 1'b0;
            tx_full       <= 1'b0;
            tx_hold       <= '0;
            tx_ready      <= 1'b0;
            rx_valid      <= 1'b0;
            rx_data       <= '0;
            cfg_done      <= 1'b0;
            status        <= '0;
            mst.mst_en    <= 1'b0;
            mst.mst_wr    <= 1'b0;
            mst.mst_addr  <= '0;
            mst.mst_wdata <= '0;
            mst.mst_strb  <= '0;
        end else begin
            // Registered so it only rises the cycle after the hold has been emptied
            tx_ready <= cfg_done & ~tx_full & ~tx_hs;
            if (tx_hs) begin
                tx_full <= 1'b1;
                tx_hold <= tx_data;
            end
            if (rx_hs)
                rx_valid <= 1'b0;

            if (state != GAP && !mst.mst_en) begin
                mst.mst_en    <= 1'b1;
                mst.mst_wr    <= req_wr;
                mst.mst_addr  <= req_addr;
                mst.mst_wdata <= req_wdata;
                mst.mst_strb  <= req_strb;
            end else if (acc_done) begin
                mst.mst_en <= 1'b0;
                case (state)
                    INIT_DIV:  state <= INIT_CTRL;
                    INIT_CTRL: begin
                        cfg_done <= 1'b1;
                        state    <= GAP;
                    end
                    POLL: begin
                        status <= mst.mst_rdata[15:0];
                        // On contention, serve whichever side was not served last
                        if (tx_elig && (!rx_elig || !prio_rx))
                            state <= TX_WR;
                        else if (rx_elig)
                            state <= RX_RD;
                        else
                            state <= GAP;
                    end
                    TX_WR: begin
                        tx_full <= 1'b0;
                        prio_rx <= 1'b1;
                        bypass  <= 1'b1;
                        state   <= GAP;
                    end
                    RX_RD: begin
                        rx_data  <= mst.mst_rdata[7:0];
                        rx_valid <= 1'b1;
                        prio_rx  <= 1'b0;
                        bypass   <= 1'b1;
                        state    <= GAP;
                    end
                    default: state <= GAP;
                endcase
            end

            if (state == GAP) begin
                if (bypass || gap_cnt == GAP_LAST) begin
                    gap_cnt <= '0;
                    bypass  <= 1'b0;
                    state   <= POLL;
                end else begin
                    gap_cnt <= gap_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_friscv_uart_host.sv
// Directed bench for friscv_uart_host: a UART register-file model answers the bus
// and logs every completed access; each task drives one scenario and checks it inline.
module tb_friscv_uart_host;

    logic        aclk = 1'b0;
    logic        srst = 1'b1;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [7:0]  tx_data = 8'h00;
    logic        rx_valid;
    logic        rx_ready = 1'b0;
    logic [7:0]  rx_data;
    logic        cfg_done;
    logic [15:0] status;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    friscv_uart_host_if #(.ADDRW(16), .XLEN(32)) bus ();

    friscv_uart_host #(
        .ADDRW(16), .XLEN(32), .CLK_DIVIDER(4), .CTRL_INIT(8'h01), .POLL_GAP(8)
    ) dut (
        .aclk     (aclk),
        .srst     (srst),
        .mst      (bus),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .rx_data  (rx_data),
        .cfg_done (cfg_done),
        .status   (status)
    );

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    // UART register model: knobs written by the tests, log written by the model
    logic        stall      = 1'b0;
    logic [15:0] stat_val   = 16'h0A01;
    int          busy_limit = 0;
    logic [7:0]  rx_byte    = 8'h00;

    int          poll_cnt = 0;
    int          n_log    = 0;
    logic        log_wr    [0:1023];
    logic [15:0] log_addr  [0:1023];
    logic [31:0] log_wdata [0:1023];
    logic [3:0]  log_strb  [0:1023];
    int          log_cyc   [0:1023];
    int          log_poll  [0:1023];

    always @(negedge aclk) begin
        if (bus.mst_en && !bus.mst_ready && !stall && !srst) begin
            bus.mst_ready = 1'b1;
            bus.mst_rdata = 32'h0;
            if (!bus.mst_wr && bus.mst_addr == 16'd0) begin
                bus.mst_rdata = {16'hDEAD, (poll_cnt < busy_limit) ? (stat_val | 16'h0400) : stat_val};
                poll_cnt = poll_cnt + 1;
            end else if (!bus.mst_wr && bus.mst_addr == 16'd3) begin
                bus.mst_rdata = {24'h123456, rx_byte};
            end
            if (n_log < 1024) begin
                log_wr[n_log]    = bus.mst_wr;
                log_addr[n_log]  = bus.mst_addr;
                log_wdata[n_log] = bus.mst_wdata;
                log_strb[n_log]  = bus.mst_strb;
                log_cyc[n_log]   = cyc;
                log_poll[n_log]  = poll_cnt;
                n_log = n_log + 1;
            end
        end else begin
            bus.mst_ready = 1'b0;
        end
    end

    function automatic int find_next(input logic [15:0] addr, input logic wr, input int from);
        for (int i = from; i < n_log; i++)
            if (log_addr[i] == addr && log_wr[i] == wr) return i;
        return -1;
    endfunction

    task automatic test_reset();
        srst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge aclk); #1;
            checks++;
            if (bus.mst_en !== 1'b0) begin
                failures++;
                $display("FAIL reset_mst_en: got %b expected 0", bus.mst_en);
            end
        end
        checks++;
        if ({cfg_done, tx_ready, rx_valid} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 000", {cfg_done, tx_ready, rx_valid});
        end
        checks++;
        if ({status, rx_data, bus.mst_wr, bus.mst_addr, bus.mst_wdata, bus.mst_strb} !== '0) begin
            failures++;
            $display("FAIL reset_data: got st=%h rx=%h wr=%b a=%h wd=%h s=%h expected all 0",
                     status, rx_data, bus.mst_wr, bus.mst_addr, bus.mst_wdata, bus.mst_strb);
        end
    endtask

    task automatic test_init(input string tag);
        int  base;
        bit  ok;
        logic mid_done;
        base = n_log;
        mid_done = 1'bx;
        srst = 1'b0;
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(posedge aclk); #1;
            if (n_log == base + 1) mid_done = cfg_done;
            if (n_log >= base + 2) ok = 1;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s_timeout: got %0d accesses expected 2", tag, n_log - base);
        end else begin
            checks++;
            if ({log_wr[base], log_addr[base], log_wdata[base], log_strb[base]} !== {1'b1, 16'h1, 32'h4, 4'h3}) begin
                failures++;
                $display("FAIL %s_div: got wr=%b a=%h wd=%h s=%h expected wr=1 a=1 wd=4 s=3", tag,
                         log_wr[base], log_addr[base], log_wdata[base], log_strb[base]);
            end
            checks++;
            if ({log_wr[base+1], log_addr[base+1], log_wdata[base+1], log_strb[base+1]} !== {1'b1, 16'h0, 32'h1, 4'h1}) begin
                failures++;
                $display("FAIL %s_ctrl: got wr=%b a=%h wd=%h s=%h expected wr=1 a=0 wd=1 s=1", tag,
                         log_wr[base+1], log_addr[base+1], log_wdata[base+1], log_strb[base+1]);
            end
            checks++;
            if ({mid_done, cfg_done} !== 2'b01) begin
                failures++;
                $display("FAIL %s_cfg_done: got mid=%b end=%b expected mid=0 end=1", tag, mid_done, cfg_done);
            end
            checks++;
            if (tx_ready !== 1'b0) begin
                failures++;
                $display("FAIL %s_tx_ready_early: got %b expected 0", tag, tx_ready);
            end
            @(posedge aclk); #1;
            checks++;
            if (tx_ready !== 1'b1) begin
                failures++;
                $display("FAIL %s_tx_ready_rise: got %b expected 1", tag, tx_ready);
            end
        end
    endtask

    task automatic test_first_poll();
        int start;
        bit ok;
        start = poll_cnt;
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(posedge aclk); #1;
            if (poll_cnt > start) ok = 1;
        end
        checks++;
        if (!ok || status !== 16'h0A01) begin
            failures++;
            $display("FAIL first_poll_status: got %h expected 0a01 (seen=%0d)", status, ok);
        end
    endtask

    task automatic offer_tx(input logic [7:0] b);
        for (int i = 0; i < 40 && tx_ready !== 1'b1; i++) begin
            @(posedge aclk); #1;
        end
        tx_data  = b;
        tx_valid = 1'b1;
        @(posedge aclk); #1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
    endtask

    task automatic test_tx();
        int base, idx, nxt;
        bit seen_ready;
        base = n_log;
        offer_tx(8'h5A);
        checks++;
        if (tx_ready !== 1'b0) begin
            failures++;
            $display("FAIL tx_ready_after_hs: got %b expected 0", tx_ready);
        end
        idx = -1;
        seen_ready = 0;
        for (int i = 0; i < 60 && idx < 0; i++) begin
            @(posedge aclk); #1;
            idx = find_next(16'd2, 1'b1, base);
            if (idx < 0 && tx_ready) seen_ready = 1;
        end
        checks++;
        if (idx < 0) begin
            failures++;
            $display("FAIL tx_write_timeout: got no addr2 write expected one");
        end else begin
            checks++;
            if ({log_wdata[idx], log_strb[idx]} !== {32'h0000005A, 4'h1}) begin
                failures++;
                $display("FAIL tx_write_data: got wd=%h s=%h expected wd=0000005a s=1", log_wdata[idx], log_strb[idx]);
            end
            checks++;
            if ({seen_ready, tx_ready} !== 2'b00) begin
                failures++;
                $display("FAIL tx_ready_hold: got seen=%b at_done=%b expected 0 0", seen_ready, tx_ready);
            end
            @(posedge aclk); #1;
            checks++;
            if (tx_ready !== 1'b1) begin
                failures++;
                $display("FAIL tx_ready_reopen: got %b expected 1", tx_ready);
            end
            repeat (30) @(posedge aclk);
            #1;
            nxt = find_next(16'd0, 1'b0, idx + 1);
            checks++;
            if (find_next(16'd2, 1'b1, idx + 1) >= 0 || nxt < 0 || (log_cyc[nxt] - log_cyc[idx]) > 4) begin
                failures++;
                $display("FAIL tx_single_and_bypass: got extra=%0d next_poll_idx=%0d expected no extra write, poll within 4 cycles",
                         find_next(16'd2, 1'b1, idx + 1), nxt);
            end
        end
    endtask

    task automatic test_tx_busy();
        int base, idx, npoll, min_gap, prev;
        base = n_log;
        busy_limit = poll_cnt + 3;
        offer_tx(8'hC3);
        idx = -1;
        for (int i = 0; i < 120 && idx < 0; i++) begin
            @(posedge aclk); #1;
            idx = find_next(16'd2, 1'b1, base);
        end
        checks++;
        if (idx < 0) begin
            failures++;
            $display("FAIL busy_write_timeout: got no addr2 write expected one");
        end else begin
            checks++;
            if (log_poll[idx] != busy_limit + 1 || log_wdata[idx] !== 32'h000000C3) begin
                failures++;
                $display("FAIL busy_write_after_free_poll: got polls=%0d wd=%h expected polls=%0d wd=000000c3",
                         log_poll[idx], log_wdata[idx], busy_limit + 1);
            end
            npoll = 0;
            min_gap = 1000;
            prev = -1;
            for (int i = base; i < idx; i++) begin
                if (log_addr[i] == 16'd0 && !log_wr[i]) begin
                    npoll++;
                    if (prev >= 0 && (log_cyc[i] - prev) < min_gap) min_gap = log_cyc[i] - prev;
                    prev = log_cyc[i];
                end
            end
            checks++;
            if (npoll != 4 || min_gap < 9) begin
                failures++;
                $display("FAIL busy_poll_spacing: got polls=%0d min_gap=%0d expected polls=4 min_gap>=9", npoll, min_gap);
            end
        end
    endtask

    task automatic test_rx();
        int base, idx, idx2;
        bit bad;
        rx_ready = 1'b0;
        rx_byte  = 8'hA5;
        base = n_log;
        stat_val = 16'h0201;
        idx = -1;
        for (int i = 0; i < 40 && idx < 0; i++) begin
            @(posedge aclk); #1;
            idx = find_next(16'd3, 1'b0, base);
        end
        checks++;
        if (idx < 0) begin
            failures++;
            $display("FAIL rx_read_timeout: got no addr3 read expected one");
        end else begin
            checks++;
            if ({rx_valid, rx_data, status} !== {1'b1, 8'hA5, 16'h0201}) begin
                failures++;
                $display("FAIL rx_capture: got v=%b d=%h st=%h expected v=1 d=a5 st=0201", rx_valid, rx_data, status);
            end
            bad = 0;
            for (int i = 0; i < 20; i++) begin
                @(posedge aclk); #1;
                if (rx_valid !== 1'b1 || rx_data !== 8'hA5) bad = 1;
            end
            checks++;
            if (bad || find_next(16'd3, 1'b0, idx + 1) >= 0) begin
                failures++;
                $display("FAIL rx_backpressure: got unstable=%b extra_read_idx=%0d expected 0 -1",
                         bad, find_next(16'd3, 1'b0, idx + 1));
            end
            rx_byte  = 8'h3C;
            rx_ready = 1'b1;
            @(posedge aclk); #1;
            rx_ready = 1'b0;
            checks++;
            if (rx_valid !== 1'b0) begin
                failures++;
                $display("FAIL rx_clear: got %b expected 0", rx_valid);
            end
            idx2 = -1;
            for (int i = 0; i < 40 && idx2 < 0; i++) begin
                @(posedge aclk); #1;
                idx2 = find_next(16'd3, 1'b0, idx + 1);
            end
            checks++;
            if (idx2 < 0 || {rx_valid, rx_data} !== {1'b1, 8'h3C}) begin
                failures++;
                $display("FAIL rx_second: got idx=%0d v=%b d=%h expected v=1 d=3c", idx2, rx_valid, rx_data);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [7:0]  bytes [4];
        logic [15:0] seq;
        logic [31:0] txd;
        int base, sent, ndata, ntx;
        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44;
        base = n_log;
        sent = 0;
        ndata = 0;
        rx_ready = 1'b1;
        for (int i = 0; i < 400 && ndata < 8; i++) begin
            @(posedge aclk); #1;
            if (tx_valid) begin
                sent++;
                tx_valid = 1'b0;
            end
            if (tx_ready && sent < 4) begin
                tx_valid = 1'b1;
                tx_data  = bytes[sent];
            end
            ndata = 0;
            for (int j = base; j < n_log; j++)
                if (log_addr[j] == 16'd2 || log_addr[j] == 16'd3) ndata++;
        end
        tx_valid = 1'b0;
        seq = '0;
        txd = '0;
        ndata = 0;
        ntx = 0;
        for (int j = base; j < n_log && ndata < 8; j++) begin
            if (log_addr[j] == 16'd2 || log_addr[j] == 16'd3) begin
                seq = {seq[13:0], log_addr[j][1:0]};
                ndata++;
                if (log_addr[j] == 16'd2 && ntx < 4) begin
                    txd = {txd[23:0], log_wdata[j][7:0]};
                    ntx++;
                end
            end
        end
        checks++;
        if (seq !== 16'hBBBB) begin
            failures++;
            $display("FAIL rr_order: got %h expected bbbb (2 bits per access, 2=tx 3=rx)", seq);
        end
        checks++;
        if (txd !== 32'h11223344) begin
            failures++;
            $display("FAIL rr_tx_data: got %h expected 11223344", txd);
        end
        stat_val = 16'h0A01;
        repeat (20) @(posedge aclk);
        #1;
        rx_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit ok;
        int base;
        stall = 1'b1;
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(posedge aclk); #1;
            if (bus.mst_en) ok = 1;
        end
        offer_tx(8'h77);
        checks++;
        if (!ok || bus.mst_en !== 1'b1 || tx_ready !== 1'b0) begin
            failures++;
            $display("FAIL mid_setup: got en_seen=%0d en=%b tx_ready=%b expected 1 1 0", ok, bus.mst_en, tx_ready);
        end
        srst = 1'b1;
        @(posedge aclk); #1;
        checks++;
        if ({bus.mst_en, cfg_done, tx_ready, rx_valid, status} !== '0) begin
            failures++;
            $display("FAIL mid_reset: got en=%b cfg=%b txr=%b rxv=%b st=%h expected all 0",
                     bus.mst_en, cfg_done, tx_ready, rx_valid, status);
        end
        stall = 1'b0;
        @(posedge aclk); #1;
        test_init("reinit");
        base = n_log;
        repeat (40) @(posedge aclk);
        #1;
        checks++;
        if (find_next(16'd2, 1'b1, base) >= 0 || tx_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_hold_emptied: got write_idx=%0d tx_ready=%b expected -1 1",
                     find_next(16'd2, 1'b1, base), tx_ready);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_init("init");
        test_first_poll();
        test_tx();
        test_tx_busy();
        test_rx();
        test_round_robin();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
